xbar_req_sched: RTL and testbench
=================================

// Module: xbar_req_sched
// PURPOSE
//  Control/scheduling half of the crossbar request buffer. Tracks the 8-entry request store of each upstream
//  channel, allocates its write slot, queues entries per target bank in arrival order, arbitrates round-robin
//  among channels per bank, and drives the buffer's w_ptr / entry-1hot / channel-1hot selects plus bank valid.
// PARAMETERS
//  CH_NUM     3  upstream channels
//  BANK_NUM   4  downstream banks; BANK_W = $clog2(BANK_NUM)
//  ENTRY_NUM  8  store entries per channel; PTR_W = $clog2(ENTRY_NUM)
// PORTS
//  clk                 in   1                    clock
//  rst                 in   1                    reset, asynchronous, active-high
//  u_ch_req_valid      in   CH_NUM               upstream request valid per channel
//  u_ch_req_bank       in   CH_NUM*BANK_W        target bank per channel (ch c at [c*BANK_W +: BANK_W])
//  u_ch_req_ready      out  CH_NUM               channel has a free entry
//  ch_w_ptr            out  CH_NUM*PTR_W         store entry written on handshake, per channel
//  d_bank_valid        out  BANK_NUM             selected request presented to bank
//  d_bank_ready        in   BANK_NUM             bank accepts request
//  bank_ch_1hot_id     out  BANK_NUM*CH_NUM      granted channel per bank, one-hot, 0 when !valid
//  ch_bank_r_entry_1hot_id out CH_NUM*BANK_NUM*ENTRY_NUM  read entry per (ch,bank), one-hot, idx (c*BANK_NUM+b)
// BEHAVIOUR
//  State per channel: entry_vld[ENTRY_NUM]; per (ch,bank): in-order FIFO of entry ids, depth ENTRY_NUM, with count.
//  State per bank: round-robin pointer rr[CH_NUM] (one-hot), reset to channel 0.
//  Reset (async, rst=1): all entry_vld=0, FIFOs empty, rr=ch0. Outputs: u_ch_req_ready=all 1, ch_w_ptr=0,
//   d_bank_valid=0, all 1hot ids=0.
//  Allocation: ch_w_ptr[c] = lowest index with entry_vld=0 (0 if none); u_ch_req_ready[c] = |~entry_vld.
//   Handshake (valid&ready) at edge T: entry_vld[w_ptr] set, id pushed to FIFO(c,u_ch_req_bank[c]).
//   Entry eligible for bank arbitration from cycle T+1 (no bypass; one-cycle min latency).
//  Read select: ch_bank_r_entry_1hot_id(c,b) = one-hot of FIFO(c,b) head when non-empty, else 0.
//  Arbitration per bank b: requesters = channels with FIFO(c,b) non-empty; grant = first requester at/after rr[b]
//   in increasing channel order, wrapping. d_bank_valid[b] = |requesters. Grant is a pure function of state;
//   must not depend on d_bank_ready. Held stable until handshake (state changes only on handshakes).
//  Bank handshake (d_bank_valid&d_bank_ready) at edge: pop FIFO(g,b), clear entry_vld of popped id,
//   rr[b] <= channel after g (wrap). No handshake: rr unchanged.
//  Simultaneous events:
//   - free and alloc in same channel same cycle: w_ptr computed from pre-edge entry_vld; freed slot usable next cycle.
//   - up to BANK_NUM pops from one channel in one cycle (distinct banks) all take effect.
//   - push and pop on same (c,b) FIFO same cycle: both occur, count unchanged; pop of full-channel state frees
//     a slot and ready rises next cycle.
//   - push to empty FIFO never popped same cycle (not yet eligible).
//  Full: all ENTRY_NUM entries valid -> ready=0, w_ptr=0, upstream valid ignored. FIFO cannot overflow
//   (total occupancy per channel <= ENTRY_NUM).
//  FIFO pointers wrap modulo ENTRY_NUM. Out-of-range bank id (BANK_NUM not power of 2) is an assertion error.
//  Reset mid-operation: all queued requests discarded, outputs return to reset values asynchronously.
//  Assertions: 1hot outputs are one-hot-or-zero; bank_ch_1hot_id!=0 iff d_bank_valid; popped entry was valid.
// TESTING
//  1 Reset then ch0 req bank2 at cycle 1 -> w_ptr0=0, cycle 2 d_bank_valid=4'b0100, bank_ch_1hot_id[b2]=3'b001,
//    r_entry(0,2)=8'h01; ready2=1 -> entry 0 freed, valid drops.
//  2 Ch1 sends 8 reqs to bank0 with d_bank_ready=0 -> w_ptr 0..7, ready1=0 after 8th; valid ignored; raise
//    ready -> entries drain in order 0..7 (1hot 01,02,..,80), ready1 returns 1 cycle after first pop.
//  3 All 3 channels hold bank3 reqs, d_bank_ready[3]=1 -> grants 001,010,100,001 rotating; stall ready
//    mid-sequence -> grant/1hot hold stable.
//  4 Ch2 queues banks 0,1,2,3 in entries 0-3, all banks ready -> 4 pops same cycle, entry_vld clears to 0.
//  5 Channel full, same cycle bank pops entry 5 and upstream valid -> no accept that cycle; next cycle
//    ready=1, w_ptr=5.
//  6 Assert rst with 5 entries queued across banks -> outputs zero/ready=all 1 immediately; post-release
//    first req gets w_ptr=0.

Source files
------------

// File: rtl/xbar_req_sched.sv
// Crossbar request buffer scheduler: per-channel entry allocation,
// per (channel,bank) in-order queues and per-bank round-robin grant.
module xbar_req_sched #(
  parameter  int CH_NUM    = 3,
  parameter  int BANK_NUM  = 4,
  parameter  int ENTRY_NUM = 8,
  localparam int BANK_W    = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1,
  localparam int PTR_W     = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CH_NUM-1:0]                    u_ch_req_valid,
  input  logic [CH_NUM*BANK_W-1:0]             u_ch_req_bank,
  output logic [CH_NUM-1:0]                    u_ch_req_ready,
  output logic [CH_NUM*PTR_W-1:0]              ch_w_ptr,
  output logic [BANK_NUM-1:0]                  d_bank_valid,
  input  logic [BANK_NUM-1:0]                  d_bank_ready,
  output logic [BANK_NUM*CH_NUM-1:0]           bank_ch_1hot_id,
  output logic [CH_NUM*BANK_NUM*ENTRY_NUM-1:0] ch_bank_r_entry_1hot_id
);

  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ptr_t LAST = ptr_t'(ENTRY_NUM - 1);

  logic [ENTRY_NUM-1:0] vld     [CH_NUM];
  logic [ENTRY_NUM-1:0] vld_nxt [CH_NUM];
  ptr_t                 mem     [CH_NUM][BANK_NUM][ENTRY_NUM];
  ptr_t                 rd      [CH_NUM][BANK_NUM];
  ptr_t                 wr      [CH_NUM][BANK_NUM];
  cnt_t                 cnt     [CH_NUM][BANK_NUM];
  ptr_t                 hd      [CH_NUM][BANK_NUM];
  logic [CH_NUM-1:0]    rr      [BANK_NUM];
  logic [CH_NUM-1:0]    req     [BANK_NUM];
  logic [CH_NUM-1:0]    gnt     [BANK_NUM];
  ptr_t                 wp      [CH_NUM];
  logic [BANK_W-1:0]    bsel    [CH_NUM];
  logic [BANK_NUM-1:0]  push    [CH_NUM];
  logic [BANK_NUM-1:0]  pop     [CH_NUM];
  logic [CH_NUM-1:0]    acc;
  logic [BANK_NUM-1:0]  bhs;

  function automatic ptr_t inc(input ptr_t p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Lowest free entry per channel and the upstream handshake.
  always_comb begin
    ch_w_ptr = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      wp[c] = '0;
      for (int e = ENTRY_NUM - 1; e >= 0; e--)
        if (!vld[c][e]) wp[c] = ptr_t'(e);
      u_ch_req_ready[c] = ~&vld[c];
      acc[c]  = u_ch_req_valid[c] & u_ch_req_ready[c];
      bsel[c] = u_ch_req_bank[c*BANK_W +: BANK_W];
      ch_w_ptr[c*PTR_W +: PTR_W] = wp[c];
    end
  end

  // Round-robin pick of the first non-empty channel at/after rr.
  always_comb begin
    int rr_idx;
    int idx;
    d_bank_valid    = '0;
    bank_ch_1hot_id = '0;
    bhs             = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      rr_idx = 0;
      for (int s = 0; s < CH_NUM; s++)
        if (rr[b][s]) rr_idx = s;
      for (int c = 0; c < CH_NUM; c++)
        req[b][c] = (cnt[c][b] != '0);
      gnt[b] = '0;
      for (int k = CH_NUM - 1; k >= 0; k--) begin
        idx = rr_idx + k;
        if (idx >= CH_NUM) idx = idx - CH_NUM;
        if (req[b][idx]) begin
          gnt[b]      = '0;
          gnt[b][idx] = 1'b1;
        end
      end
      d_bank_valid[b] = |req[b];
      bank_ch_1hot_id[b*CH_NUM +: CH_NUM] = gnt[b];
      bhs[b] = d_bank_valid[b] & d_bank_ready[b];
    end
  end

  // Queue heads, push/pop strobes and next entry-valid vector.
  always_comb begin
    logic [ENTRY_NUM-1:0] oh;
    ch_bank_r_entry_1hot_id = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      vld_nxt[c] = vld[c];
      if (acc[c]) vld_nxt[c][wp[c]] = 1'b1;
      for (int b = 0; b < BANK_NUM; b++) begin
        hd[c][b]   = mem[c][b][rd[c][b]];
        push[c][b] = acc[c] && (bsel[c] == BANK_W'(b));
        pop[c][b]  = bhs[b] && gnt[b][c];
        oh = '0;
        if (cnt[c][b] != '0) oh[hd[c][b]] = 1'b1;
        ch_bank_r_entry_1hot_id[(c*BANK_NUM+b)*ENTRY_NUM +: ENTRY_NUM] = oh;
        if (pop[c][b]) vld_nxt[c][hd[c][b]] = 1'b0;
      end
    end
  end

  // Control state: entry valids, queue pointers/counts, rr pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH_NUM; c++) begin
        vld[c] <= '0;
        for (int b = 0; b < BANK_NUM; b++) begin
          rd[c][b]  <= '0;
          wr[c][b]  <= '0;
          cnt[c][b] <= '0;
        end
      end
      for (int b = 0; b < BANK_NUM; b++)
        rr[b] <= CH_NUM'(1);
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        vld[c] <= vld_nxt[c];
        for (int b = 0; b < BANK_NUM; b++) begin
          if (push[c][b]) wr[c][b] <= inc(wr[c][b]);
          if (pop[c][b])  rd[c][b] <= inc(rd[c][b]);
          if (push[c][b] && !pop[c][b])
            cnt[c][b] <= cnt[c][b] + 1'b1;
          else if (pop[c][b] && !push[c][b])
            cnt[c][b] <= cnt[c][b] - 1'b1;
        end
      end
      for (int b = 0; b < BANK_NUM; b++)
        if (bhs[b])
          rr[b] <= {gnt[b][CH_NUM-2:0], gnt[b][CH_NUM-1]};
    end
  end

  // Entry-id storage; contents only matter while counted.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CH_NUM; c++)
      for (int b = 0; b < BANK_NUM; b++)
        if (push[c][b]) mem[c][b][wr[c][b]] <= wp[c];
  end

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank_chk
    a_gnt_oh: assert property (@(posedge clk) disable iff (rst)
      $onehot0(gnt[b]));
    a_gnt_v: assert property (@(posedge clk) disable iff (rst)
      ((gnt[b] != '0) == d_bank_valid[b]));
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch_chk
    a_bank_rng: assert property (@(posedge clk) disable iff (rst)
      acc[c] |-> (int'(bsel[c]) < BANK_NUM));
    for (genvar b = 0; b < BANK_NUM; b++) begin : g_cb
      a_pop_vld: assert property (@(posedge clk) disable iff (rst)
        pop[c][b] |-> vld[c][hd[c][b]]);
      a_ent_oh: assert property (@(posedge clk) disable iff (rst)
        $onehot0(ch_bank_r_entry_1hot_id[(c*BANK_NUM+b)*ENTRY_NUM +: ENTRY_NUM]));
    end
  end

endmodule

// File: tb/tb_xbar_req_sched.sv
// Scoreboard bench for xbar_req_sched: expected bank grants are queued
// per bank at issue time and checked by a monitor on each bank handshake.
module tb_xbar_req_sched;

  localparam int CH = 3;
  localparam int BK = 4;
  localparam int EN = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [CH-1:0]  u_ch_req_valid;
  logic [CH*2-1:0] u_ch_req_bank;
  logic [CH-1:0]  u_ch_req_ready;
  logic [CH*3-1:0] ch_w_ptr;
  logic [BK-1:0]  d_bank_valid;
  logic [BK-1:0]  d_bank_ready;
  logic [BK*CH-1:0] bank_ch_1hot_id;
  logic [CH*BK*EN-1:0] ch_bank_r_entry_1hot_id;

  xbar_req_sched dut (
    .clk                     (clk),
    .rst                     (rst),
    .u_ch_req_valid          (u_ch_req_valid),
    .u_ch_req_bank           (u_ch_req_bank),
    .u_ch_req_ready          (u_ch_req_ready),
    .ch_w_ptr                (ch_w_ptr),
    .d_bank_valid            (d_bank_valid),
    .d_bank_ready            (d_bank_ready),
    .bank_ch_1hot_id         (bank_ch_1hot_id),
    .ch_bank_r_entry_1hot_id (ch_bank_r_entry_1hot_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ch1h;
    int         ci;
    logic [7:0] ent;
  } exp_t;

  exp_t q [BK][$];
  exp_t mx;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [2:0] gnt(input int b);
    return bank_ch_1hot_id[b*CH +: CH];
  endfunction

  function automatic logic [7:0] rent(input int c, input int b);
    return ch_bank_r_entry_1hot_id[(c*BK+b)*EN +: EN];
  endfunction

  function automatic logic [2:0] wptr(input int c);
    return ch_w_ptr[c*3 +: 3];
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input int b, input int c, input int e);
    exp_t x;
    x.ch1h = 3'(1 << c);
    x.ci   = c;
    x.ent  = 8'(1 << e);
    q[b].push_back(x);
  endtask

  function automatic logic all_empty();
    logic r;
    r = 1'b1;
    for (int b = 0; b < BK; b++)
      if (q[b].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input string n);
    logic done;
    done = 1'b0;
    d_bank_ready = 4'hf;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      done = all_empty() && (d_bank_valid == '0);
    end
    chk({n, " drain"}, 32'(done), 32'd1);
    d_bank_ready = 4'h0;
  endtask

  // Monitor: every bank handshake pops and compares one expected item.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int b = 0; b < BK; b++) begin
        if (d_bank_valid[b] && d_bank_ready[b]) begin
          if (q[b].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected bank%0d grant: got ch %b expected none",
                     b, gnt(b));
          end else begin
            mx = q[b].pop_front();
            chk($sformatf("grant b%0d", b), 32'(gnt(b)), 32'(mx.ch1h));
            chk($sformatf("entry c%0d b%0d", mx.ci, b),
                32'(rent(mx.ci, b)), 32'(mx.ent));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    u_ch_req_valid = '0;
    u_ch_req_bank  = '0;
    d_bank_ready   = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst ready", 32'(u_ch_req_ready), 32'h7);
    chk("rst wptr", 32'(ch_w_ptr), 32'h0);
    chk("rst bvalid", 32'(d_bank_valid), 32'h0);
    chk("rst gnt", 32'(|bank_ch_1hot_id), 32'h0);
    chk("rst rent", 32'(|ch_bank_r_entry_1hot_id), 32'h0);

    // 1: single request ch0 -> bank2
    tick();
    u_ch_req_valid = 3'b001;
    u_ch_req_bank  = {2'd0, 2'd0, 2'd2};
    @(negedge clk);
    chk("s1 wptr0", 32'(wptr(0)), 32'h0);
    expect_req(2, 0, 0);
    tick();
    u_ch_req_valid = '0;
    @(negedge clk);
    chk("s1 bvalid", 32'(d_bank_valid), 32'h4);
    chk("s1 gnt b2", 32'(gnt(2)), 32'h1);
    chk("s1 rent 0,2", 32'(rent(0, 2)), 32'h1);
    tick();
    d_bank_ready = 4'b0100;
    @(negedge clk);
    tick();
    d_bank_ready = '0;
    @(negedge clk);
    chk("s1 bvalid off", 32'(d_bank_valid), 32'h0);

    // 2: ch1 fills all 8 entries towards bank0
    for (int i = 0; i < 8; i++) begin
      tick();
      u_ch_req_valid = 3'b010;
      u_ch_req_bank  = '0;
      @(negedge clk);
      chk($sformatf("s2 wptr1 #%0d", i), 32'(wptr(1)), 32'(i));
      chk($sformatf("s2 ready1 #%0d", i), 32'(u_ch_req_ready[1]), 32'h1);
      expect_req(0, 1, i);
    end
    tick();
    @(negedge clk);
    chk("s2 full ready1", 32'(u_ch_req_ready[1]), 32'h0);
    chk("s2 full wptr1", 32'(wptr(1)), 32'h0);
    tick();
    u_ch_req_valid = '0;
    d_bank_ready   = 4'b0001;
    @(negedge clk);
    chk("s2 ready1 pre-pop", 32'(u_ch_req_ready[1]), 32'h0);
    tick();
    @(negedge clk);
    chk("s2 ready1 post-pop", 32'(u_ch_req_ready[1]), 32'h1);
    chk("s2 wptr1 post-pop", 32'(wptr(1)), 32'h0);
    drain("s2");

    // 3: three channels share bank3, round-robin with stall
    tick();
    u_ch_req_valid = 3'b111;
    u_ch_req_bank  = {2'd3, 2'd3, 2'd3};
    @(negedge clk);
    chk("s3 wptr0", 32'(wptr(0)), 32'h0);
    chk("s3 wptr1", 32'(wptr(1)), 32'h0);
    chk("s3 wptr2", 32'(wptr(2)), 32'h0);
    expect_req(3, 0, 0);
    expect_req(3, 1, 0);
    expect_req(3, 2, 0);
    expect_req(3, 0, 1);
    tick();
    u_ch_req_valid = 3'b001;
    @(negedge clk);
    chk("s3 wptr0 2nd", 32'(wptr(0)), 32'h1);
    tick();
    u_ch_req_valid = '0;
    @(negedge clk);
    chk("s3 gnt first", 32'(gnt(3)), 32'h1);
    tick();
    d_bank_ready = 4'b1000;
    @(negedge clk);
    tick();
    d_bank_ready = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("s3 hold gnt %0d", i), 32'(gnt(3)), 32'h2);
      chk($sformatf("s3 hold rent %0d", i), 32'(rent(1, 3)), 32'h1);
      tick();
    end
    drain("s3");

    // 4: ch2 hits all four banks, popped in one cycle
    for (int i = 0; i < 4; i++) begin
      tick();
      u_ch_req_valid = 3'b100;
      u_ch_req_bank  = {2'(i), 4'b0};
      @(negedge clk);
      chk($sformatf("s4 wptr2 #%0d", i), 32'(wptr(2)), 32'(i));
      expect_req(i, 2, i);
    end
    tick();
    u_ch_req_valid = '0;
    d_bank_ready   = 4'hf;
    @(negedge clk);
    chk("s4 bvalid all", 32'(d_bank_valid), 32'hf);
    tick();
    d_bank_ready = '0;
    @(negedge clk);
    chk("s4 bvalid none", 32'(d_bank_valid), 32'h0);
    chk("s4 wptr2", 32'(wptr(2)), 32'h0);
    chk("s4 ready", 32'(u_ch_req_ready), 32'h7);

    // 5: full ch0, pop entry 5 while upstream is valid
    for (int i = 0; i < 8; i++) begin
      tick();
      u_ch_req_valid = 3'b001;
      u_ch_req_bank  = {4'b0, (i == 5) ? 2'd1 : 2'd0};
      @(negedge clk);
      chk($sformatf("s5 wptr0 #%0d", i), 32'(wptr(0)), 32'(i));
      expect_req((i == 5) ? 1 : 0, 0, i);
    end
    tick();
    u_ch_req_bank = {4'b0, 2'd2};
    d_bank_ready  = 4'b0010;
    @(negedge clk);
    chk("s5 full ready0", 32'(u_ch_req_ready[0]), 32'h0);
    chk("s5 full wptr0", 32'(wptr(0)), 32'h0);
    tick();
    d_bank_ready = '0;
    @(negedge clk);
    chk("s5 freed ready0", 32'(u_ch_req_ready[0]), 32'h1);
    chk("s5 freed wptr0", 32'(wptr(0)), 32'h5);
    expect_req(2, 0, 5);
    tick();
    u_ch_req_valid = '0;
    @(negedge clk);
    chk("s5 refull ready0", 32'(u_ch_req_ready[0]), 32'h0);
    drain("s5");

    // 6: asynchronous reset with requests queued
    tick();
    u_ch_req_valid = 3'b111;
    u_ch_req_bank  = {2'd2, 2'd1, 2'd0};
    tick();
    u_ch_req_valid = 3'b011;
    u_ch_req_bank  = {2'd0, 2'd0, 2'd3};
    tick();
    u_ch_req_valid = '0;
    @(negedge clk);
    chk("s6 bvalid queued", 32'(d_bank_valid), 32'hf);
    #2 rst = 1'b1;
    #1;
    chk("s6 rst ready", 32'(u_ch_req_ready), 32'h7);
    chk("s6 rst wptr", 32'(ch_w_ptr), 32'h0);
    chk("s6 rst bvalid", 32'(d_bank_valid), 32'h0);
    chk("s6 rst gnt", 32'(|bank_ch_1hot_id), 32'h0);
    chk("s6 rst rent", 32'(|ch_bank_r_entry_1hot_id), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    u_ch_req_valid = 3'b010;
    u_ch_req_bank  = {2'd0, 2'd1, 2'd0};
    @(negedge clk);
    chk("s6 post wptr1", 32'(wptr(1)), 32'h0);
    expect_req(1, 1, 0);
    tick();
    u_ch_req_valid = '0;
    drain("s6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
